// File: rtl/jtag_mem_bridge_if.sv
// Request/response and memory-bus signal bundle between the JTAG TAP side and the bridge.
// The bridge uses the slave view; the TAP logic and the memory together use the master view.
interface jtag_mem_bridge_if;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LEVEL_W = 8;
    localparam int unsigned CODE_W  = 8;
    localparam int unsigned CNT_W   = 8;

    // Request side, one transfer per completed Update-DR
    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [ADDR_W-1:0]  req_addr;
    logic [DATA_W-1:0]  req_wdata;
    logic               debug_mode;
    logic [LEVEL_W-1:0] access_level;

    // Status returned to the TAP for the next Capture-DR
    logic               rsp_valid;
    logic [DATA_W-1:0]  rd_data;
    logic               error;
    logic [CODE_W-1:0]  error_code;
    logic [CNT_W-1:0]   err_count;

    // Single-beat on-chip memory bus
    logic               mem_req;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic               mem_ack;
    logic [DATA_W-1:0]  mem_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, debug_mode, access_level,
        input  req_ready, rsp_valid, rd_data, error, error_code, err_count,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, debug_mode, access_level,
        output req_ready, rsp_valid, rd_data, error, error_code, err_count,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );
endinterface

// File: rtl/jtag_mem_bridge.sv
// JTAG memory-access engine: checks rights, range and alignment of a TAP request,
// runs one bus beat with timeout and holds read data / error status for Capture-DR.
module jtag_mem_bridge #(
    parameter logic [31:0] ADDR_LIMIT     = 32'h0010_0000,
    parameter logic [7:0]  RD_MIN_LEVEL   = 8'h40,
    parameter logic [7:0]  WR_MIN_LEVEL   = 8'h80,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    jtag_mem_bridge_if.slave  bus
);
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned LEVEL_W = 8;
    localparam int unsigned CODE_W  = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TMO_W   = 8;

    localparam logic [CODE_W-1:0] CODE_NONE    = 8'h00;
    localparam logic [CODE_W-1:0] CODE_RANGE   = 8'h01;
    localparam logic [CODE_W-1:0] CODE_DENIED  = 8'h02;
    localparam logic [CODE_W-1:0] CODE_TIMEOUT = 8'h03;
    localparam logic [CODE_W-1:0] CODE_ALIGN   = 8'h04;

    localparam logic [CNT_W-1:0]  CNT_MAX  = 8'hFF;
    // Counter value seen in the last permitted BUS cycle
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        BUS,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    // Captured request
    logic               req_wr_q;
    logic [ADDR_W-1:0]  req_addr_q;
    logic [DATA_W-1:0]  req_wdata_q;
    logic               req_dbg_q;
    logic [LEVEL_W-1:0] req_lvl_q;

    // Registered outputs
    logic               ready_q;
    logic               rsp_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [DATA_W-1:0]  rd_q;
    logic               err_q;
    logic [CODE_W-1:0]  code_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [TMO_W-1:0]   tmo_cnt;

    // Next-state decode
    logic               accept;
    logic               ack_hit;
    logic [CODE_W-1:0]  chk_code;
    logic [CODE_W-1:0]  code_nxt;
    logic [LEVEL_W-1:0] min_level;

    // Request screening in fixed priority: rights, then range, then alignment
    always_comb begin
        chk_code  = CODE_NONE;
        min_level = req_wr_q ? WR_MIN_LEVEL : RD_MIN_LEVEL;
        if (!req_dbg_q && (req_lvl_q < min_level)) begin
            chk_code = CODE_DENIED;
        end else if (req_addr_q >= ADDR_LIMIT) begin
            chk_code = CODE_RANGE;
        end else if (req_addr_q[1:0] != 2'b00) begin
            chk_code = CODE_ALIGN;
        end
    end

    // State transitions and status-code update
    always_comb begin
        state_nxt = state;
        code_nxt  = code_q;
        accept    = 1'b0;
        ack_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    accept    = 1'b1;
                    code_nxt  = CODE_NONE;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                code_nxt  = chk_code;
                state_nxt = (chk_code != CODE_NONE) ? RESP : BUS;
            end
            BUS: begin
                // An ack in the final permitted cycle still completes the access
                if (bus.mem_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = RESP;
                end else if (tmo_cnt == TMO_LAST) begin
                    code_nxt  = CODE_TIMEOUT;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request capture, bus strobes and held status
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_wr_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_dbg_q   <= 1'b0;
            req_lvl_q   <= '0;
            ready_q     <= 1'b0;
            rsp_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            rd_q        <= '0;
            err_q       <= 1'b0;
            code_q      <= CODE_NONE;
            cnt_q       <= '0;
            tmo_cnt     <= '0;
        end else begin
            ready_q   <= (state_nxt == IDLE);
            rsp_q     <= (state_nxt == RESP);
            mem_req_q <= (state_nxt == BUS);
            mem_we_q  <= (state_nxt == BUS) && req_wr_q;
            code_q    <= code_nxt;

            if (accept) begin
                req_wr_q    <= bus.req_write;
                req_addr_q  <= bus.req_addr;
                req_wdata_q <= bus.req_wdata;
                req_dbg_q   <= bus.debug_mode;
                req_lvl_q   <= bus.access_level;
                err_q       <= 1'b0;
            end else if (state_nxt == RESP) begin
                err_q <= (code_nxt != CODE_NONE);
            end

            if ((state_nxt == RESP) && (code_nxt != CODE_NONE) && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (state == BUS) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end

            if (ack_hit && !req_wr_q) begin
                rd_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.rsp_valid  = rsp_q;
    assign bus.rd_data    = rd_q;
    assign bus.error      = err_q;
    assign bus.error_code = code_q;
    assign bus.err_count  = cnt_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = req_addr_q;
    assign bus.mem_wdata  = req_wdata_q;

endmodule

// File: tb/tb_jtag_mem_bridge.sv
// Bench for jtag_mem_bridge: directed vector table, randomized requests against a
// rule-level model, error-counter saturation and reset during a bus cycle.
module tb_jtag_mem_bridge;
    localparam logic [31:0] ADDR_LIMIT = 32'h0010_0000;
    localparam int unsigned RD_MIN     = 32'h40;
    localparam int unsigned WR_MIN     = 32'h80;
    localparam int unsigned TMO        = 255;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          dbg;
        logic [7:0]  lvl;
        int          ack_k;     // BUS cycle in which ack is given; 0 = never
        logic [31:0] rdata;
        bit          stray;     // drive mem_ack while mem_req is low
        bit          extra;     // pulse req_valid during BUS
        logic [7:0]  exp_code;
    } vec_t;

    typedef struct {
        bit          done;
        int          lat;
        int          bus_cyc;
        bit          bad_bus;
        logic        err;
        logic [7:0]  code;
        logic [31:0] rd;
        logic [7:0]  cnt;
        logic        rsp_after;
        logic        ready_after;
        bit          held;
    } obs_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    jtag_mem_bridge_if b();

    jtag_mem_bridge dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] m_rd = 32'h0;
    int m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] wd, bit dbg, logic [7:0] lvl,
                                int ack, logic [31:0] rd, bit stray, bit extra, logic [7:0] code);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = wd; v.dbg = dbg; v.lvl = lvl;
        v.ack_k = ack; v.rdata = rd; v.stray = stray; v.extra = extra; v.exp_code = code;
        return v;
    endfunction

    // Outcome code from the access rules, including the bus timeout
    function automatic logic [7:0] model_code(vec_t v);
        int unsigned need;
        need = v.write ? WR_MIN : RD_MIN;
        if (!v.dbg && (int'(v.lvl) < int'(need))) return 8'h02;
        if (v.addr >= ADDR_LIMIT) return 8'h01;
        if ((v.addr % 4) != 0) return 8'h04;
        if ((v.ack_k == 0) || (v.ack_k > int'(TMO))) return 8'h03;
        return 8'h00;
    endfunction

    task automatic check_idle_outputs(input string tag, input logic exp_ready);
        chk({tag, ".req_ready"},  32'(b.req_ready), 32'(exp_ready));
        chk({tag, ".mem_req"},    32'(b.mem_req), 0);
        chk({tag, ".mem_we"},     32'(b.mem_we), 0);
        chk({tag, ".rsp_valid"},  32'(b.rsp_valid), 0);
        chk({tag, ".error"},      32'(b.error), 0);
        chk({tag, ".error_code"}, 32'(b.error_code), 0);
        chk({tag, ".err_count"},  32'(b.err_count), 0);
        chk({tag, ".rd_data"},    b.rd_data, 0);
    endtask

    task automatic run_req(input string tag, input vec_t v, output obs_t o);
        int w;
        o.done = 0; o.lat = 0; o.bus_cyc = 0; o.bad_bus = 0; o.held = 0;
        w = 0;
        while (!b.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, ".ready_wait"}, 32'(b.req_ready), 1);
        b.req_valid    = 1'b1;
        b.req_write    = v.write;
        b.req_addr     = v.addr;
        b.req_wdata    = v.wdata;
        b.debug_mode   = v.dbg;
        b.access_level = v.lvl;
        b.mem_ack      = v.stray;
        b.mem_rdata    = $urandom;
        @(negedge clk);
        b.req_valid = 1'b0;
        o.lat = 1;
        while (o.lat < 300) begin
            if (b.rsp_valid) break;
            if (b.mem_req) begin
                o.bus_cyc++;
                if (b.mem_addr !== v.addr || b.mem_we !== v.write || (v.write && b.mem_wdata !== v.wdata))
                    o.bad_bus = 1;
                b.req_valid = 1'b0;
                b.mem_ack   = (v.ack_k != 0) && (o.bus_cyc == v.ack_k);
                b.mem_rdata = v.rdata;
                if (v.extra && o.bus_cyc == 1) begin
                    b.req_valid = 1'b1;
                    b.req_addr  = v.addr ^ 32'h10;
                    b.req_write = ~v.write;
                end
            end else begin
                b.req_valid = 1'b0;
                b.mem_ack   = v.stray;
                b.mem_rdata = $urandom;
            end
            @(negedge clk);
            o.lat++;
        end
        o.done = b.rsp_valid;
        o.err  = b.error;
        o.code = b.error_code;
        o.rd   = b.rd_data;
        o.cnt  = b.err_count;
        b.req_valid = 1'b0;
        b.mem_ack   = 1'b0;
        @(negedge clk);
        o.rsp_after   = b.rsp_valid;
        o.ready_after = b.req_ready;
        o.held = (b.error === o.err) && (b.error_code === o.code) &&
                 (b.rd_data === o.rd) && (b.err_count === o.cnt);
    endtask

    task automatic verify(input string tag, input vec_t v, input obs_t o, input logic [7:0] exp_code);
        int exp_bus;
        if (exp_code == 8'h00) begin
            exp_bus = v.ack_k;
            if (!v.write) m_rd = v.rdata;
        end else if (exp_code == 8'h03) begin
            exp_bus = int'(TMO);
        end else begin
            exp_bus = 0;
        end
        if (exp_code != 8'h00 && m_cnt < 255) m_cnt++;
        chk({tag, ".done"},        32'(o.done), 1);
        chk({tag, ".latency"},     32'(o.lat), 32'(2 + exp_bus));
        chk({tag, ".bus_cycles"},  32'(o.bus_cyc), 32'(exp_bus));
        chk({tag, ".bus_stable"},  32'(o.bad_bus), 0);
        chk({tag, ".error"},       32'(o.err), 32'(exp_code != 8'h00));
        chk({tag, ".error_code"},  32'(o.code), 32'(exp_code));
        chk({tag, ".rd_data"},     o.rd, m_rd);
        chk({tag, ".err_count"},   32'(o.cnt), 32'(m_cnt));
        chk({tag, ".rsp_pulse"},   32'(o.rsp_after), 0);
        chk({tag, ".ready_after"}, 32'(o.ready_after), 1);
        chk({tag, ".status_hold"}, 32'(o.held), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        obs_t o;

        b.req_valid = 1'b0; b.req_write = 1'b0; b.req_addr = '0; b.req_wdata = '0;
        b.debug_mode = 1'b0; b.access_level = '0; b.mem_ack = 1'b0; b.mem_rdata = '0;

        //          wr addr          wdata         dbg lvl    ack rdata         stray extra code
        tbl.push_back(mk(1, 32'h0000_0100, 32'hDEADBEEF, 1, 8'h00, 2,   32'h0,        0, 0, 8'h00));
        tbl.push_back(mk(0, 32'h0000_0100, 32'h0,        1, 8'h00, 1,   32'hDEADBEEF, 0, 0, 8'h00));
        tbl.push_back(mk(1, 32'h0020_0000, 32'h11111111, 1, 8'h00, 1,   32'h0,        1, 0, 8'h01));
        tbl.push_back(mk(1, 32'h0000_0200, 32'h22222222, 0, 8'h40, 1,   32'h0,        0, 0, 8'h02));
        tbl.push_back(mk(0, 32'h0000_0200, 32'h0,        0, 8'h40, 3,   32'h12345678, 1, 0, 8'h00));
        tbl.push_back(mk(0, 32'h0000_0102, 32'h0,        1, 8'h00, 1,   32'h0,        0, 0, 8'h04));
        tbl.push_back(mk(0, 32'h0000_0300, 32'h0,        1, 8'h00, 0,   32'hBAD0BAD0, 0, 0, 8'h03));
        tbl.push_back(mk(0, 32'h0000_0400, 32'h0,        1, 8'h00, 255, 32'hCAFEF00D, 1, 0, 8'h00));
        tbl.push_back(mk(1, 32'h0000_0104, 32'h33333333, 1, 8'h00, 4,   32'h0,        0, 1, 8'h00));
        tbl.push_back(mk(0, 32'h0020_0002, 32'h0,        0, 8'h00, 1,   32'h0,        0, 0, 8'h02));
        tbl.push_back(mk(0, 32'h0010_0001, 32'h0,        1, 8'h00, 1,   32'h0,        0, 0, 8'h01));
        tbl.push_back(mk(0, 32'h000F_FFFC, 32'h0,        0, 8'h40, 1,   32'h0BADCAFE, 0, 0, 8'h00));
        tbl.push_back(mk(0, 32'h0010_0000, 32'h0,        1, 8'h00, 1,   32'h0,        0, 0, 8'h01));
        tbl.push_back(mk(1, 32'h0000_0800, 32'h44444444, 0, 8'h80, 1,   32'h0,        0, 0, 8'h00));
        tbl.push_back(mk(1, 32'h0000_0800, 32'h55555555, 0, 8'h7F, 1,   32'h0,        0, 0, 8'h02));
        tbl.push_back(mk(0, 32'h0000_0800, 32'h0,        0, 8'h3F, 1,   32'h0,        0, 0, 8'h02));
        tbl.push_back(mk(0, 32'h0000_0004, 32'h0,        1, 8'h00, 0,   32'h0,        0, 0, 8'h03));

        // Outputs during and right after reset
        repeat (3) @(negedge clk);
        check_idle_outputs("reset", 1'b0);
        reset_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset", 1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            run_req($sformatf("vec%0d", i), tbl[i], o);
            verify($sformatf("vec%0d", i), tbl[i], o, tbl[i].exp_code);
        end

        for (int i = 0; i < 40; i++) begin
            v.write = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       v.addr = ADDR_LIMIT + 32'($urandom_range(0, 64));
                1:       v.addr = $urandom;
                2:       v.addr = ADDR_LIMIT - 32'd4;
                default: begin
                    v.addr = 32'($urandom_range(0, 32'h000F_FFFF));
                    if ($urandom_range(0, 3) != 0) v.addr[1:0] = 2'b00;
                end
            endcase
            v.wdata    = $urandom;
            v.dbg      = 1'($urandom_range(0, 1));
            v.lvl      = 8'($urandom);
            v.ack_k    = $urandom_range(0, 6);
            v.rdata    = $urandom;
            v.stray    = 1'($urandom_range(0, 1));
            v.extra    = 1'($urandom_range(0, 1));
            v.exp_code = model_code(v);
            run_req($sformatf("rnd%0d", i), v, o);
            verify($sformatf("rnd%0d", i), v, o, v.exp_code);
        end

        // Drive err_count into saturation with denied writes
        v = mk(1, 32'h0000_0200, 32'h0, 0, 8'h00, 1, 32'h0, 0, 0, 8'h02);
        for (int i = 0; i < 256; i++) begin
            run_req($sformatf("sat%0d", i), v, o);
            verify($sformatf("sat%0d", i), v, o, 8'h02);
        end
        chk("sat.err_count", 32'(b.err_count), 32'hFF);

        // Reset while a read is waiting for ack
        b.req_valid = 1'b1; b.req_write = 1'b0; b.req_addr = 32'h0000_0500;
        b.debug_mode = 1'b1; b.access_level = 8'h00; b.mem_ack = 1'b0;
        @(negedge clk);
        b.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid.mem_req_before", 32'(b.mem_req), 1);
        reset_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_mid", 1'b0);
        reset_n = 1'b1;
        m_rd  = 32'h0;
        m_cnt = 0;
        @(negedge clk);
        check_idle_outputs("rst_mid_release", 1'b1);

        v = mk(1, 32'h0000_0600, 32'h5A5AA5A5, 1, 8'h00, 2, 32'h0, 0, 0, 8'h00);
        run_req("after_rst_wr", v, o);
        verify("after_rst_wr", v, o, 8'h00);
        v = mk(0, 32'h0000_0600, 32'h0, 1, 8'h00, 1, 32'h5A5AA5A5, 0, 0, 8'h00);
        run_req("after_rst_rd", v, o);
        verify("after_rst_rd", v, o, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
